leds: RTL and testbench



---
 rtl/leds.sv | 112 +++++++++++
 tb/tb_leds.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/leds.sv
// Memory-mapped 24-bit LED output port with a blink gate, written and read back
// over the 16-bit memorio bus. All state updates on the falling edge of ledclk.
module leds #(
  parameter logic [31:0] CLK_DIV = 32'd5_000_000
) (
  input  logic        ledclk,
  input  logic        ledrst,
  input  logic        ledcs,
  input  logic [1:0]  ledaddr,
  input  logic        ledwrite,
  input  logic        ledread,
  input  logic [15:0] ledwdata,
  output logic [15:0] ledrdata,
  output logic [23:0] led_o
);

  localparam logic [1:0] AddrLo    = 2'b00;
  localparam logic [1:0] AddrHi    = 2'b10;
  localparam logic [1:0] AddrBlink = 2'b11;

  logic [15:0] ledLoQ, ledLoD;
  logic [7:0]  ledHiQ, ledHiD;
  logic        blinkEnQ, blinkEnD;
  logic [2:0]  rateQ, rateD;
  logic [31:0] countQ, countD;
  logic        phaseQ, phaseD;
  logic [15:0] rdataQ, rdataD;
  logic [23:0] ledQ, ledD;

  logic        wrEn, rdEn;
  logic [31:0] limit;

  always_comb begin
    ledLoD   = ledLoQ;
    ledHiD   = ledHiQ;
    blinkEnD = blinkEnQ;
    rateD    = rateQ;
    countD   = countQ;
    phaseD   = phaseQ;
    rdataD   = rdataQ;

    // A simultaneous read and write performs only the write.
    wrEn  = ledcs & ledwrite;
    rdEn  = ledcs & ledread & ~ledwrite;
    limit = (CLK_DIV << rateQ) - 32'd1;

    if (wrEn) begin
      case (ledaddr)
        AddrLo:    ledLoD = ledwdata;
        AddrHi:    ledHiD = ledwdata[7:0];
        AddrBlink: begin
          blinkEnD = ledwdata[0];
          rateD    = ledwdata[3:1];
        end
        default: ;
      endcase
    end

    if (rdEn) begin
      case (ledaddr)
        AddrLo:    rdataD = ledLoQ;
        AddrHi:    rdataD = {8'h00, ledHiQ};
        AddrBlink: rdataD = {12'h000, rateQ, blinkEnQ};
        default:   rdataD = 16'h0000;
      endcase
    end

    // Any BLINK write restarts the half-period from the lit phase.
    if (wrEn && (ledaddr == AddrBlink)) begin
      countD = 32'd0;
      phaseD = 1'b1;
    end else if (blinkEnQ) begin
      if (countQ == limit) begin
        countD = 32'd0;
        phaseD = ~phaseQ;
      end else begin
        countD = countQ + 32'd1;
      end
    end else begin
      countD = 32'd0;
      phaseD = 1'b1;
    end

    ledD = {ledHiD, ledLoD} & {24{phaseD}};
  end

  always_ff @(negedge ledclk or negedge ledrst) begin
    if (!ledrst) begin
      ledLoQ   <= 16'h0000;
      ledHiQ   <= 8'h00;
      blinkEnQ <= 1'b0;
      rateQ    <= 3'd0;
      countQ   <= 32'd0;
      phaseQ   <= 1'b1;
      rdataQ   <= 16'h0000;
      ledQ     <= 24'h000000;
    end else begin
      ledLoQ   <= ledLoD;
      ledHiQ   <= ledHiD;
      blinkEnQ <= blinkEnD;
      rateQ    <= rateD;
      countQ   <= countD;
      phaseQ   <= phaseD;
      rdataQ   <= rdataD;
      ledQ     <= ledD;
    end
  end

  assign ledrdata = rdataQ;
  assign led_o    = ledQ;

endmodule

// File: tb/tb_leds.sv
// Randomized scoreboard bench for leds: a behavioural model predicts led_o and
// ledrdata per falling edge; a monitor pops and compares after each edge.
module tb_leds;

  localparam logic [31:0] CLK_DIV = 32'd4;

  logic        ledclk;
  logic        ledrst;
  logic        ledcs;
  logic [1:0]  ledaddr;
  logic        ledwrite;
  logic        ledread;
  logic [15:0] ledwdata;
  logic [15:0] ledrdata;
  logic [23:0] led_o;

  leds #(.CLK_DIV(CLK_DIV)) dut (
    .ledclk  (ledclk),
    .ledrst  (ledrst),
    .ledcs   (ledcs),
    .ledaddr (ledaddr),
    .ledwrite(ledwrite),
    .ledread (ledread),
    .ledwdata(ledwdata),
    .ledrdata(ledrdata),
    .led_o   (led_o)
  );

  typedef struct {
    logic [23:0] led;
    logic [15:0] rd;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   failures = 0;

  // Model state: register contents plus edges elapsed since the blink restart.
  logic [15:0] mLo;
  logic [7:0]  mHi;
  bit          mEn;
  logic [2:0]  mRate;
  longint      mT;
  logic [15:0] mRd;

  initial begin
    ledclk = 1'b1;
    forever #5 ledclk = ~ledclk;
  end

  function automatic bit modelPhase();
    longint half;
    half = longint'(CLK_DIV) << mRate;
    if (!mEn) return 1'b1;
    return ((mT / half) % 2) == 0;
  endfunction

  function automatic logic [15:0] modelRead(input logic [1:0] addr);
    case (addr)
      2'b00:   return mLo;
      2'b10:   return {8'h00, mHi};
      2'b11:   return {12'h000, mRate, mEn};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic modelReset();
    mLo = 16'h0000; mHi = 8'h00; mEn = 1'b0; mRate = 3'd0; mT = 0; mRd = 16'h0000;
  endtask

  task automatic checkOutput(input string name, input logic [23:0] actual,
                             input logic [23:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one bus cycle at the rising edge and predict the following falling edge.
  task automatic applyStimulus(input bit rst, input bit cs, input logic [1:0] addr,
                               input bit wr, input bit rd, input logic [15:0] data);
    exp_t e;
    bit   blinkWr;
    @(posedge ledclk);
    ledrst = rst; ledcs = cs; ledaddr = addr; ledwrite = wr; ledread = rd; ledwdata = data;
    if (!rst) begin
      modelReset();
      e.led = 24'h000000;
      e.rd  = 16'h0000;
    end else begin
      if (cs && rd && !wr) mRd = modelRead(addr);
      blinkWr = cs && wr && (addr == 2'b11);
      if (cs && wr) begin
        case (addr)
          2'b00: mLo = data;
          2'b10: mHi = data[7:0];
          2'b11: begin mEn = data[0]; mRate = data[3:1]; end
          default: ;
        endcase
      end
      if (blinkWr || !mEn) mT = 0;
      else mT = mT + 1;
      e.led = modelPhase() ? {mHi, mLo} : 24'h000000;
      e.rd  = mRd;
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'b00, 0, 0, 16'h0000);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ledclk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("led_o", led_o, e.led);
        checkOutput("ledrdata", {8'h00, ledrdata}, {8'h00, e.rd});
      end
    end
  end

  initial begin : stimulus
    bit           rst, cs, wr, rd;
    logic [1:0]   addr;
    logic [15:0]  data;
    int           guard;
    ledrst = 1'b0; ledcs = 1'b0; ledaddr = 2'b00; ledwrite = 1'b0; ledread = 1'b0;
    ledwdata = 16'h0000;
    modelReset();

    // Writes strobed during reset must not land.
    applyStimulus(0, 1, 2'b00, 1, 0, 16'hFFFF);
    applyStimulus(0, 1, 2'b10, 1, 0, 16'hFFFF);
    applyStimulus(0, 1, 2'b11, 1, 1, 16'h000F);
    applyStimulus(1, 0, 2'b00, 0, 0, 16'h0000);
    applyStimulus(1, 1, 2'b00, 0, 1, 16'h0000);

    // Static image write and readback.
    applyStimulus(1, 1, 2'b00, 1, 0, 16'hA5C3);
    applyStimulus(1, 1, 2'b10, 1, 0, 16'hFF7E);
    applyStimulus(1, 1, 2'b10, 0, 1, 16'h0000);
    idle(2);

    // Blink enable at rate 1: eight lit edges, eight dark edges.
    applyStimulus(1, 1, 2'b11, 1, 0, 16'h0003);
    applyStimulus(1, 1, 2'b11, 0, 1, 16'h0000);
    idle(20);

    // Disable mid-period, then re-enable for a full half-period.
    applyStimulus(1, 1, 2'b11, 1, 0, 16'h0000);
    idle(3);
    applyStimulus(1, 1, 2'b11, 1, 0, 16'h0003);
    idle(12);
    applyStimulus(1, 1, 2'b00, 1, 0, 16'h0F0F);
    idle(10);

    // Collisions, deselected writes and the reserved address.
    applyStimulus(1, 1, 2'b00, 1, 1, 16'h1234);
    applyStimulus(1, 0, 2'b00, 1, 0, 16'hDEAD);
    applyStimulus(1, 1, 2'b01, 1, 0, 16'hBEEF);
    applyStimulus(1, 1, 2'b00, 0, 1, 16'h0000);
    applyStimulus(1, 1, 2'b01, 0, 1, 16'h0000);
    applyStimulus(1, 1, 2'b00, 0, 1, 16'h0000);

    // Async reset in the dark phase, asserted between edges.
    applyStimulus(1, 1, 2'b11, 1, 0, 16'h0001);
    guard = 0;
    while (modelPhase() && guard < 20) begin
      idle(1);
      guard++;
    end
    if (guard >= 20) checkOutput("reach_dark_phase", 24'd1, 24'd0);
    @(negedge ledclk);
    #3;
    ledrst = 1'b0;
    #1;
    checkOutput("async_led_o", led_o, 24'h000000);
    checkOutput("async_ledrdata", {8'h00, ledrdata}, 24'h000000);
    modelReset();
    applyStimulus(0, 1, 2'b00, 1, 0, 16'hFFFF);
    applyStimulus(0, 1, 2'b11, 1, 0, 16'h0001);
    applyStimulus(1, 0, 2'b00, 0, 0, 16'h0000);
    applyStimulus(1, 1, 2'b11, 0, 1, 16'h0000);
    applyStimulus(1, 1, 2'b00, 0, 1, 16'h0000);
    idle(6);

    // Randomized traffic with occasional blink reprogramming and resets.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 599) != 0);
      cs   = ($urandom_range(0, 9) != 0);
      addr = 2'($urandom_range(0, 3));
      wr   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 3) == 0);
      data = 16'($urandom);
      if (addr == 2'b11 && wr) begin
        if ($urandom_range(0, 5) != 0) wr = 1'b0;
        data[3:1] = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) data[0] = 1'b1;
      end
      applyStimulus(rst, cs, addr, wr, rd, data);
    end
    idle(2);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge ledclk);
      guard++;
    end
    #2;
    if (expQ.size() > 0) checkOutput("scoreboard_drain", 24'(expQ.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
